// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction SRAM and hands
// fetched words to decode over a valid/ready handshake.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          RD_LAT   = 1,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             imem_cs,
  output logic             imem_oe,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_din,
  input  logic [31:0]      imem_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  output logic [CNT_W-1:0] instr_count,
  output logic             misalign_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;

  localparam logic [3:0] LAST_WAIT = 4'(RD_LAT - 1);

  state_t      state;
  state_t      next_state;
  logic [31:0] pc;
  logic [3:0]  wait_cnt;
  logic        handshake;
  logic        fetch_done;

  assign handshake  = out_valid && out_ready;
  assign fetch_done = (state == REQ) && (wait_cnt == LAST_WAIT);

  // SRAM strobes come straight from the state register so no input can glitch them
  assign imem_cs   = (state == REQ);
  assign imem_oe   = (state == REQ);
  assign imem_we   = 1'b0;
  assign imem_din  = 32'h0000_0000;
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (redirect_valid) begin
      next_state = en ? REQ : IDLE;
    end else begin
      case (state)
        IDLE:    if (en) next_state = REQ;
        REQ:     if (fetch_done) next_state = HOLD;
        HOLD:    if (handshake) next_state = en ? REQ : IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // A redirect overrides any fetch completion, but an accept in the same cycle still counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      wait_cnt     <= 4'd0;
      instr        <= 32'h0000_0000;
      instr_pc     <= 32'h0000_0000;
      out_valid    <= 1'b0;
      instr_count  <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (handshake) begin
        instr_count <= instr_count + CNT_W'(1);
      end
      if (redirect_valid) begin
        pc        <= {redirect_pc[31:2], 2'b00};
        wait_cnt  <= 4'd0;
        out_valid <= 1'b0;
        if (redirect_pc[1:0] != 2'b00) begin
          misalign_err <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            wait_cnt <= 4'd0;
          end
          REQ: begin
            if (fetch_done) begin
              instr     <= imem_dout;
              instr_pc  <= pc;
              pc        <= pc + 32'd4;
              out_valid <= 1'b1;
              wait_cnt  <= 4'd0;
            end else begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end
          HOLD: begin
            if (handshake) begin
              out_valid <= 1'b0;
            end
          end
          default: begin
            wait_cnt <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances (RD_LAT=1 and RD_LAT=3 with a narrow
// counter) share stimulus and are compared against a transaction-level model.
module tb_instr_fetch;

  localparam logic [31:0] RPC1 = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic        a_cs, a_oe, a_we, a_valid, a_mis;
  logic [31:0] a_addr, a_din, a_dout, a_instr, a_ipc;
  logic [15:0] a_cnt;
  logic        b_cs, b_oe, b_we, b_valid, b_mis;
  logic [31:0] b_addr, b_din, b_dout, b_instr, b_ipc;
  logic [3:0]  b_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: m_rem is the number of SRAM read cycles still to go
  int          m_rem   [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_instr [2];
  logic [31:0] m_ipc   [2];
  logic        m_valid [2];
  logic        m_mis   [2];
  logic [15:0] m_cnt   [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] sram(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h2009_0007;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign a_dout = sram(a_addr);
  assign b_dout = sram(b_addr);

  instr_fetch #(.RESET_PC(32'h0), .RD_LAT(1), .CNT_W(16)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_cs(a_cs), .imem_oe(a_oe), .imem_we(a_we), .imem_addr(a_addr),
    .imem_din(a_din), .imem_dout(a_dout),
    .out_valid(a_valid), .out_ready(out_ready),
    .instr(a_instr), .instr_pc(a_ipc), .instr_count(a_cnt), .misalign_err(a_mis)
  );

  instr_fetch #(.RESET_PC(RPC1), .RD_LAT(3), .CNT_W(4)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_cs(b_cs), .imem_oe(b_oe), .imem_we(b_we), .imem_addr(b_addr),
    .imem_din(b_din), .imem_dout(b_dout),
    .out_valid(b_valid), .out_ready(out_ready),
    .instr(b_instr), .instr_pc(b_ipc), .instr_count(b_cnt), .misalign_err(b_mis)
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [148:0] dut_vec(input int k);
    if (k == 0)
      return {a_cs, a_oe, a_we, a_addr, a_din, a_valid, a_instr, a_ipc, a_cnt, a_mis};
    return {b_cs, b_oe, b_we, b_addr, b_din, b_valid, b_instr, b_ipc, 12'h000, b_cnt, b_mis};
  endfunction

  function automatic logic [148:0] mdl_vec(input int k);
    logic busy;
    busy = (m_rem[k] > 0);
    return {busy, busy, 1'b0, m_pc[k], 32'h0, m_valid[k], m_instr[k], m_ipc[k], m_cnt[k], m_mis[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rem[k]   = 0;
      m_pc[k]    = (k == 0) ? 32'h0 : RPC1;
      m_instr[k] = 32'h0;
      m_ipc[k]   = 32'h0;
      m_valid[k] = 1'b0;
      m_mis[k]   = 1'b0;
      m_cnt[k]   = 16'h0;
    end
  endtask

  task automatic model_update();
    logic hs;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        hs = m_valid[k] && out_ready;
        if (hs) m_cnt[k] = (m_cnt[k] + 16'd1) & ((k == 0) ? 16'hFFFF : 16'h000F);
        if (redirect_valid) begin
          m_pc[k]    = {redirect_pc[31:2], 2'b00};
          m_valid[k] = 1'b0;
          m_rem[k]   = en ? lat_of(k) : 0;
          if (redirect_pc[1:0] != 2'b00) m_mis[k] = 1'b1;
        end else if (m_rem[k] > 0) begin
          m_rem[k] = m_rem[k] - 1;
          if (m_rem[k] == 0) begin
            m_instr[k] = sram(m_pc[k]);
            m_ipc[k]   = m_pc[k];
            m_pc[k]    = m_pc[k] + 32'd4;
            m_valid[k] = 1'b1;
          end
        end else if (m_valid[k]) begin
          if (hs) begin
            m_valid[k] = 1'b0;
            m_rem[k]   = en ? lat_of(k) : 0;
          end
        end else begin
          m_rem[k] = en ? lat_of(k) : 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 2) rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          errors++;
          $display("[TB] FAIL reset inst%0d got=%h exp=%h", k, dut_vec(k), mdl_vec(k));
        end
      end
    end
    checks++;
    if ({a_cs, a_valid, a_addr, a_cnt} !== {1'b0, 1'b0, 32'h0, 16'h0}) begin
      errors++;
      $display("[TB] FAIL reset_values got=%h exp=%h", {a_cs, a_valid, a_addr, a_cnt}, 50'h0);
    end
  endtask

  task automatic test_basic();
    en = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          errors++;
          $display("[TB] FAIL basic inst%0d cyc%0d got=%h exp=%h", k, i, dut_vec(k), mdl_vec(k));
        end
      end
      if (i == 2 || i == 4) begin
        checks++;
        if ({a_valid, a_instr, a_ipc} !== {1'b1, (i == 2) ? 32'h2008_0005 : 32'h2009_0007,
                                           (i == 2) ? 32'h0 : 32'h4}) begin
          errors++;
          $display("[TB] FAIL basic_instr cyc%0d got=%h/%h exp_pc=%0d", i, a_instr, a_ipc, (i == 2) ? 0 : 4);
        end
      end
    end
    checks++;
    if ({a_cnt, a_addr, a_cs} !== {16'd2, 32'h8, 1'b1}) begin
      errors++;
      $display("[TB] FAIL basic_count got cnt=%0d addr=%h exp cnt=2 addr=8", a_cnt, a_addr);
    end
  endtask

  task automatic test_stall();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          errors++;
          $display("[TB] FAIL stall inst%0d got=%h exp=%h", k, dut_vec(k), mdl_vec(k));
        end
      end
      checks++;
      if ({a_valid, a_cs, a_instr} !== {1'b1, 1'b0, sram(32'h8)}) begin
        errors++;
        $display("[TB] FAIL stall_hold got v=%b cs=%b instr=%h exp v=1 cs=0 instr=%h", a_valid, a_cs, a_instr, sram(32'h8));
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if ({a_cnt, a_addr, a_cs, a_valid} !== {16'd3, 32'hC, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL stall_release got cnt=%0d addr=%h cs=%b exp cnt=3 addr=c cs=1", a_cnt, a_addr, a_cs);
    end
  endtask

  task automatic test_redirect();
    logic [15:0] exp_cnt;
    for (int pass = 0; pass < 2; pass++) begin
      out_ready = 1'b0;
      for (int i = 0; i < 10 && !m_valid[0]; i++) step();
      exp_cnt        = m_cnt[0] + 16'(pass);
      out_ready      = (pass == 1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      step();
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      checks++;
      if ({a_valid, a_cnt, a_addr, a_cs} !== {1'b0, exp_cnt, 32'h40, 1'b1}) begin
        errors++;
        $display("[TB] FAIL redirect_hold pass%0d got v=%b cnt=%0d addr=%h exp v=0 cnt=%0d addr=40", pass, a_valid, a_cnt, a_addr, exp_cnt);
      end
      step();
      checks++;
      if ({a_valid, a_ipc} !== {1'b1, 32'h40}) begin
        errors++;
        $display("[TB] FAIL redirect_fetch pass%0d got v=%b pc=%h exp v=1 pc=40", pass, a_valid, a_ipc);
      end
    end
    out_ready = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step();
    redirect_valid = 1'b0;
    checks++;
    if ({a_valid, a_addr, a_ipc} !== {1'b0, 32'h80, 32'h40}) begin
      errors++;
      $display("[TB] FAIL redirect_drop got v=%b addr=%h ipc=%h exp v=0 addr=80 ipc=40", a_valid, a_addr, a_ipc);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_vec(k) !== mdl_vec(k)) begin
        errors++;
        $display("[TB] FAIL redirect inst%0d got=%h exp=%h", k, dut_vec(k), mdl_vec(k));
      end
    end
  endtask

  task automatic test_misalign();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    step();
    redirect_valid = 1'b0;
    checks++;
    if ({a_addr, a_mis, b_mis} !== {32'h40, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL misalign_set got addr=%h err=%b/%b exp addr=40 err=1/1", a_addr, a_mis, b_mis);
    end
    for (int i = 0; i < 24; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          errors++;
          $display("[TB] FAIL misalign inst%0d got=%h exp=%h", k, dut_vec(k), mdl_vec(k));
        end
      end
    end
    checks++;
    if (a_mis !== 1'b1) begin
      errors++;
      $display("[TB] FAIL misalign_sticky got=%b exp=1", a_mis);
    end
  endtask

  task automatic test_midreset();
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20 && m_rem[1] != 2; i++) step();
    checks++;
    if (b_cs !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_req got cs=%b exp cs=1", b_cs);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_vec(k) !== mdl_vec(k)) begin
        errors++;
        $display("[TB] FAIL midreset inst%0d got=%h exp=%h", k, dut_vec(k), mdl_vec(k));
      end
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({b_addr, b_cs, a_addr, a_cs, b_mis} !== {RPC1, 1'b1, 32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midreset_restart got b=%h/%b a=%h/%b err=%b exp b=100/1 a=0/1 err=0", b_addr, b_cs, a_addr, a_cs, b_mis);
    end
  endtask

  task automatic test_pc_wrap();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    checks++;
    if ({a_valid, a_ipc, a_addr} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
      errors++;
      $display("[TB] FAIL pc_wrap got v=%b ipc=%h addr=%h exp v=1 ipc=fffffffc addr=0", a_valid, a_ipc, a_addr);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          errors++;
          $display("[TB] FAIL pc_wrap inst%0d got=%h exp=%h", k, dut_vec(k), mdl_vec(k));
        end
      end
    end
  endtask

  task automatic test_count_wrap();
    en = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          errors++;
          $display("[TB] FAIL count_wrap inst%0d got=%h exp=%h", k, dut_vec(k), mdl_vec(k));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en             = ($urandom_range(0, 7) != 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'hFFFF_FFFC;
        1:       redirect_pc = $urandom;
        default: redirect_pc = {$urandom_range(0, 255), 2'b00};
      endcase
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          errors++;
          $display("[TB] FAIL random inst%0d cyc%0d got=%h exp=%h", k, i, dut_vec(k), mdl_vec(k));
        end
      end
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_misalign();
    test_midreset();
    test_pc_wrap();
    test_count_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
